// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock front-end and lock FSM.
package lock_pkg;

  localparam int unsigned N_KEYS_DEF   = 4;
  localparam int unsigned KEY_W        = $clog2(N_KEYS_DEF);
  localparam int unsigned DEBOUNCE_DEF = 16;

  typedef logic [KEY_W-1:0] key_code_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_REL = 1'b1
  } kc_state_e;

endpackage

// File: rtl/lock_debounce.sv
// One button: 2-flop synchroniser followed by a saturating-run debouncer
// that only moves the stable level after DEBOUNCE_CYCLES consecutive differing samples.
module lock_debounce
  import lock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = din;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/lock_key_conditioner.sv
// Button front-end for the lock: debounced press detection, one key code per press
// over valid/ready, plus a clear strobe and overrun indication.
module lock_key_conditioner
  import lock_pkg::*;
#(
  parameter int unsigned N_KEYS          = N_KEYS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_KEYS-1:0]                    key_raw,
  input  logic                                 clr_raw,
  output logic                                 key_valid,
  output logic [((N_KEYS > 1) ? $clog2(N_KEYS) : 1)-1:0] key_code,
  input  logic                                 key_ready,
  output logic                                 clr_pulse,
  output logic                                 overrun,
  output logic                                 busy
);

  localparam int unsigned KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  logic [N_KEYS-1:0] key_stable;
  logic              clr_stable;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key_db
    lock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .din    (key_raw[gi]),
      .stable (key_stable[gi])
    );
  end

  lock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk    (clk),
    .rst    (rst),
    .din    (clr_raw),
    .stable (clr_stable)
  );

  logic [N_KEYS-1:0] key_prev_q, key_prev_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic              clr_prev_q, clr_prev_d;
  logic              clr_edge_q, clr_edge_d;
  kc_state_e         state_q, state_d;
  logic              key_valid_q, key_valid_d;
  logic [KW-1:0]     key_code_q, key_code_d;
  logic              clr_pulse_q, clr_pulse_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;
  logic [KW-1:0]     idx;
  logic              capture;

  // Edge strobes are registered so press/clear events line up in the same cycle.
  always_comb begin
    key_prev_d = key_stable;
    clr_prev_d = clr_stable;
    press_d    = key_stable & ~key_prev_q;
    clr_edge_d = clr_stable & ~clr_prev_q;

    idx = '0;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (press_q[i]) idx = KW'(i);
    end
    capture = (state_q == ST_IDLE) && (|press_q);

    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (|press_q) state_d = ST_WAIT_REL;
      ST_WAIT_REL: if (key_stable == '0) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_WAIT_REL);

    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overrun_d   = 1'b0;
    clr_pulse_d = clr_edge_q;
    // Clear outranks a simultaneous capture; the dropped key is not an overrun.
    if (clr_edge_q) begin
      key_valid_d = 1'b0;
    end else if (capture) begin
      if (!key_valid_q || key_ready) begin
        key_valid_d = 1'b1;
        key_code_d  = idx;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev_q  <= '0;
      press_q     <= '0;
      clr_prev_q  <= 1'b0;
      clr_edge_q  <= 1'b0;
      state_q     <= ST_IDLE;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      clr_pulse_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      key_prev_q  <= key_prev_d;
      press_q     <= press_d;
      clr_prev_q  <= clr_prev_d;
      clr_edge_q  <= clr_edge_d;
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      clr_pulse_q <= clr_pulse_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign clr_pulse = clr_pulse_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lock_key_conditioner.sv
// Scoreboard bench for lock_key_conditioner with DEBOUNCE_CYCLES=4, N_KEYS=4.
module tb_lock_key_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_raw;
  logic       clr_raw;
  logic       key_valid;
  logic [1:0] key_code;
  logic       key_ready;
  logic       clr_pulse;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ovr_seen = 0;
  int clr_seen = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_code;

  always #5 clk = ~clk;

  lock_key_conditioner #(.N_KEYS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .clr_raw   (clr_raw),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .clr_pulse (clr_pulse),
    .overrun   (overrun),
    .busy      (busy)
  );

  // Monitor: every accepted transfer must match the next expected code.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid && key_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected: got code %0d, none expected", key_code);
        end else begin
          exp_code = exp_q.pop_front();
          if (key_code !== exp_code) begin
            errors++;
            $display("FAIL xfer_code: got %0d expected %0d", key_code, exp_code);
          end
        end
      end
      if (overrun === 1'b1) ovr_seen++;
      if (clr_pulse === 1'b1) begin
        clr_seen++;
        checks++;
        if (key_valid !== 1'b0) begin
          errors++;
          $display("FAIL clr_drops_valid: key_valid=%0b expected 0", key_valid);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"},   32'(key_valid), 0);
    chk({nm, "_code"},    32'(key_code),  0);
    chk({nm, "_clr"},     32'(clr_pulse), 0);
    chk({nm, "_overrun"}, 32'(overrun),   0);
    chk({nm, "_busy"},    32'(busy),      0);
  endtask

  initial begin
    rst = 1'b1; key_raw = 4'b0000; clr_raw = 1'b0; key_ready = 1'b1;
    tick(3);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // Single press, latency 7 edges after first sample.
    key_raw = 4'b0100; exp_q.push_back(2'd2);
    tick(7);
    chk("lat_early", 32'(key_valid), 0);
    tick(1);
    chk("lat_valid", 32'(key_valid), 1);
    chk("lat_code",  32'(key_code),  2);
    chk("lat_busy",  32'(busy),      1);
    tick(1);
    chk("lat_one_cycle", 32'(key_valid), 0);
    key_raw = 4'b0000;
    tick(12);
    chk("lat_release_busy", 32'(busy), 0);

    // 3-cycle glitch is rejected.
    key_raw = 4'b0010;
    tick(3);
    key_raw = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("glitch_no_valid", 32'(key_valid), 0);
    end
    chk("glitch_busy", 32'(busy), 0);

    // Bounce then steady: exactly one key.
    exp_q.push_back(2'd1);
    key_raw = 4'b0010; tick(1);
    key_raw = 4'b0000; tick(1);
    key_raw = 4'b0010; tick(1);
    key_raw = 4'b0000; tick(1);
    key_raw = 4'b0010; tick(14);
    chk("bounce_busy", 32'(busy), 1);
    key_raw = 4'b0000; tick(12);

    // Simultaneous press: lowest index wins; no key until all released.
    key_raw = 4'b1010; exp_q.push_back(2'd1);
    tick(12);
    key_raw = 4'b1000; tick(12);
    chk("multi_hold3_busy", 32'(busy), 1);
    key_raw = 4'b1010; tick(12);
    chk("multi_repress_busy", 32'(busy), 1);
    key_raw = 4'b0000; tick(12);
    chk("multi_release_busy", 32'(busy), 0);

    // Backpressure: second press dropped with a single overrun.
    key_ready = 1'b0;
    key_raw = 4'b0001; exp_q.push_back(2'd0);
    tick(10);
    chk("bp_valid", 32'(key_valid), 1);
    chk("bp_code",  32'(key_code),  0);
    key_raw = 4'b0000; tick(12);
    chk("bp_busy_low", 32'(busy), 0);
    key_raw = 4'b0100; tick(12);
    chk("bp_code_kept",  32'(key_code),  0);
    chk("bp_valid_kept", 32'(key_valid), 1);
    chk("bp_overrun_cnt", 32'(ovr_seen), 1);
    key_raw = 4'b0000; tick(12);
    key_ready = 1'b1;
    tick(1);
    chk("bp_drained", 32'(key_valid), 0);

    // Clear drops a pending key.
    key_ready = 1'b0;
    key_raw = 4'b1000;
    tick(10);
    chk("clr_pending_valid", 32'(key_valid), 1);
    chk("clr_pending_code",  32'(key_code),  3);
    clr_raw = 1'b1;
    tick(7);
    chk("clr_early_pulse", 32'(clr_pulse), 0);
    chk("clr_early_valid", 32'(key_valid), 1);
    tick(1);
    chk("clr_pulse", 32'(clr_pulse), 1);
    chk("clr_valid", 32'(key_valid), 0);
    tick(1);
    chk("clr_pulse_once", 32'(clr_pulse), 0);
    key_raw = 4'b0000; clr_raw = 1'b0;
    tick(12);

    // Clear and key edges aligned: clear wins, FSM still busy.
    key_ready = 1'b1;
    key_raw = 4'b0001; clr_raw = 1'b1;
    tick(7);
    chk("align_early_pulse", 32'(clr_pulse), 0);
    tick(1);
    chk("align_pulse", 32'(clr_pulse), 1);
    chk("align_valid", 32'(key_valid), 0);
    chk("align_busy",  32'(busy),      1);
    tick(1);
    chk("align_valid_after", 32'(key_valid), 0);
    key_raw = 4'b0000; clr_raw = 1'b0;
    tick(12);
    chk("align_release_busy", 32'(busy), 0);

    // Reset with a pending key and a counter mid-count; held keys re-press afterwards.
    key_ready = 1'b0;
    key_raw = 4'b0100;
    tick(10);
    chk("rst_pre_valid", 32'(key_valid), 1);
    key_raw = 4'b0110;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk_all_zero("rst_mid");
    key_ready = 1'b1; exp_q.push_back(2'd1);
    rst = 1'b0;
    tick(7);
    chk("rst_fresh_early", 32'(key_valid), 0);
    tick(1);
    chk("rst_fresh_valid", 32'(key_valid), 1);
    chk("rst_fresh_code",  32'(key_code),  1);
    chk("rst_fresh_busy",  32'(busy),      1);
    key_raw = 4'b0000;
    tick(14);

    chk("end_queue_empty", 32'(exp_q.size()), 0);
    chk("end_overrun_total", 32'(ovr_seen), 1);
    chk("end_clr_total", 32'(clr_seen), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
